// File: rtl/setting_display_pkg.sv
// Shared constants and types for the settings display: segment patterns,
// settings field indices and the per-frame input snapshot.
package setting_display_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    typedef enum logic [2:0] {
        FIELD_IDLE           = 3'd0,
        FIELD_PLAYER_COUNT   = 3'd1,
        FIELD_QUESTION_COUNT = 3'd2,
        FIELD_ANSWER_TIME    = 3'd3,
        FIELD_WIN_SCORE      = 3'd4,
        FIELD_SUCCESS_SCORE  = 3'd5,
        FIELD_FAIL_SCORE     = 3'd6
    } field_e;

    typedef struct packed {
        logic [2:0] view;
        logic [2:0] state;
        logic [2:0] player_count;
        logic [3:0] question_count;
        logic [6:0] answer_time;
        logic [6:0] win_score;
        logic [3:0] success_score;
        logic [3:0] fail_score;
    } snapshot_t;

    // A dark, idle snapshot so nothing is shown until the first frame boundary.
    localparam snapshot_t SNAP_RESET = '{
        view:           3'd1,
        state:          3'd0,
        player_count:   3'd0,
        question_count: 4'd0,
        answer_time:    7'd0,
        win_score:      7'd0,
        success_score:  4'd0,
        fail_score:     4'd0
    };

    function automatic logic field_has_value(input logic [2:0] state);
        return (state >= FIELD_PLAYER_COUNT) && (state <= FIELD_FAIL_SCORE);
    endfunction

    function automatic logic [6:0] selected_value(input snapshot_t snap);
        logic [6:0] v;
        v = 7'd0;
        case (snap.state)
            FIELD_PLAYER_COUNT:   v = {4'd0, snap.player_count};
            FIELD_QUESTION_COUNT: v = {3'd0, snap.question_count};
            FIELD_ANSWER_TIME:    v = snap.answer_time;
            FIELD_WIN_SCORE:      v = snap.win_score;
            FIELD_SUCCESS_SCORE:  v = {3'd0, snap.success_score};
            FIELD_FAIL_SCORE:     v = {3'd0, snap.fail_score};
            default:              v = 7'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/setting_display_if.sv
// Settings inputs and multiplexed 7-segment outputs of the settings display.
interface setting_display_if;

    logic [2:0] view;
    logic [2:0] state;
    logic [2:0] player_count;
    logic [3:0] question_count;
    logic [6:0] answer_time;
    logic [6:0] win_score;
    logic [3:0] success_score;
    logic [3:0] fail_score;
    logic [7:0] seg_en;
    logic [7:0] seg_out;

    modport master (
        output view, state, player_count, question_count,
        output answer_time, win_score, success_score, fail_score,
        input  seg_en, seg_out
    );

    modport slave (
        input  view, state, player_count, question_count,
        input  answer_time, win_score, success_score, fail_score,
        output seg_en, seg_out
    );

endinterface

// File: rtl/setting_display_seg7_decode.sv
// Digit code to active-low segment pattern; code 10 is a dash, 11..15 blank.
module seg7_decode
    import setting_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            4'd10:   pattern = SEG_DASH;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/setting_display.sv
// Multiplexed 8-digit settings page: scans one digit per SCAN_DIV cycles,
// snapshots the inputs at each frame boundary and blinks the value field.
module setting_display
    import setting_display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic             clk,
    input  logic             rst,
    setting_display_if.slave bus
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [SCAN_W-1:0]  scan_cnt;
    logic [2:0]         idx;
    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_on;
    snapshot_t          snap;
    logic [7:0]         seg_en_q;
    logic [7:0]         seg_out_q;

    logic               wrap;
    logic               frame_edge;
    logic [2:0]         idx_next;
    snapshot_t          live;
    snapshot_t          snap_next;
    logic               blink_next;
    logic [FRAME_W-1:0] frame_next;
    logic [6:0]         value;
    logic               has_value;
    logic [3:0]         tens;
    logic [3:0]         units;
    logic               dark;
    logic [3:0]         digit_code;
    logic [7:0]         digit_pattern;

    assign wrap       = (scan_cnt == SCAN_LAST);
    assign idx_next   = idx + 3'd1;
    assign frame_edge = wrap && (idx == 3'd7);

    assign live = '{
        view:           bus.view,
        state:          bus.state,
        player_count:   bus.player_count,
        question_count: bus.question_count,
        answer_time:    bus.answer_time,
        win_score:      bus.win_score,
        success_score:  bus.success_score,
        fail_score:     bus.fail_score
    };

    // The frame starting at this edge already uses the new snapshot and blink phase.
    always_comb begin
        snap_next  = snap;
        blink_next = blink_on;
        frame_next = frame_cnt;
        if (frame_edge) begin
            snap_next = live;
            if (live.state != snap.state) begin
                blink_next = 1'b1;
                frame_next = '0;
            end else if (frame_cnt == FRAME_LAST) begin
                blink_next = ~blink_on;
                frame_next = '0;
            end else begin
                frame_next = frame_cnt + FRAME_W'(1);
            end
        end
    end

    assign value     = selected_value(snap_next);
    assign has_value = field_has_value(snap_next.state);
    assign tens      = 4'(value / 7'd10);
    assign units     = 4'(value % 7'd10);
    assign dark      = (snap_next.view != 3'd0);

    always_comb begin
        digit_code = CODE_BLANK;
        case (idx_next)
            3'd7: digit_code = {1'b0, snap_next.state};
            3'd6: digit_code = CODE_DASH;
            3'd1: begin
                if (has_value && blink_next) begin
                    if (value > 7'd99)     digit_code = CODE_DASH;
                    else if (value > 7'd9) digit_code = tens;
                    else                   digit_code = CODE_BLANK;
                end
            end
            3'd0: begin
                if (has_value && blink_next) begin
                    if (value > 7'd99) digit_code = CODE_DASH;
                    else               digit_code = units;
                end
            end
            default: digit_code = CODE_BLANK;
        endcase
    end

    seg7_decode u_decode (
        .code    (digit_code),
        .pattern (digit_pattern)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= '0;
            idx       <= 3'd0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            snap      <= SNAP_RESET;
            seg_en_q  <= 8'hFF;
            seg_out_q <= SEG_BLANK;
        end else begin
            snap      <= snap_next;
            blink_on  <= blink_next;
            frame_cnt <= frame_next;
            if (wrap) begin
                scan_cnt <= '0;
                idx      <= idx_next;
                if (dark) begin
                    seg_en_q  <= 8'hFF;
                    seg_out_q <= SEG_BLANK;
                end else begin
                    seg_en_q  <= ~(8'd1 << idx_next);
                    seg_out_q <= digit_pattern;
                end
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    assign bus.seg_en  = seg_en_q;
    assign bus.seg_out = seg_out_q;

endmodule

// File: tb/tb_setting_display.sv
// Self-checking bench for setting_display with a fast scan (4 cycles/digit, 2-frame blink).
module tb_setting_display;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;

    typedef struct {
        logic [7:0] en;
        logic [7:0] out;
        int         digit;
    } exp_t;

    logic clk;
    logic rst;

    setting_display_if bus();

    setting_display #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int wrap_cnt = 0;

    // Bench-side view of what the display should be showing this frame.
    int m_view, m_state, m_blink, m_fcnt;
    int m_pc, m_qc, m_at, m_ws, m_ss, m_fs;

    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] pat(input int d);
        case (d)
            0:       return 8'hC0;
            1:       return 8'hF9;
            2:       return 8'hA4;
            3:       return 8'hB0;
            4:       return 8'h99;
            5:       return 8'h92;
            6:       return 8'h82;
            7:       return 8'hF8;
            8:       return 8'h80;
            9:       return 8'h90;
            10:      return 8'hBF;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int model_value();
        case (m_state)
            1:       return m_pc;
            2:       return m_qc;
            3:       return m_at;
            4:       return m_ws;
            5:       return m_ss;
            6:       return m_fs;
            default: return -1;
        endcase
    endfunction

    function automatic exp_t expect_digit(input int d);
        exp_t e;
        int   v;
        e.digit = d;
        if (m_view != 0) begin
            e.en  = 8'hFF;
            e.out = 8'hFF;
            return e;
        end
        e.en = ~(8'h01 << d);
        v    = model_value();
        case (d)
            7:       e.out = pat(m_state);
            6:       e.out = 8'hBF;
            1:       e.out = (v < 0 || m_blink == 0) ? 8'hFF : (v > 99) ? 8'hBF : (v < 10) ? 8'hFF : pat(v / 10);
            0:       e.out = (v < 0 || m_blink == 0) ? 8'hFF : (v > 99) ? 8'hBF : pat(v % 10);
            default: e.out = 8'hFF;
        endcase
        return e;
    endfunction

    task automatic model_reset();
        m_view  = 1;
        m_state = 0;
        m_blink = 1;
        m_fcnt  = 0;
        m_pc = 0; m_qc = 0; m_at = 0; m_ws = 0; m_ss = 0; m_fs = 0;
        wrap_cnt = 0;
    endtask

    task automatic model_boundary();
        if (int'(bus.state) != m_state) begin
            m_blink = 1;
            m_fcnt  = 0;
        end else if (m_fcnt == BLINK_FRAMES - 1) begin
            m_blink = (m_blink == 0) ? 1 : 0;
            m_fcnt  = 0;
        end else begin
            m_fcnt++;
        end
        m_view  = int'(bus.view);
        m_state = int'(bus.state);
        m_pc = int'(bus.player_count);
        m_qc = int'(bus.question_count);
        m_at = int'(bus.answer_time);
        m_ws = int'(bus.win_score);
        m_ss = int'(bus.success_score);
        m_fs = int'(bus.fail_score);
    endtask

    // Lands 1 time unit after the edge on which the scan counter wraps.
    task automatic wait_wrap();
        repeat (SCAN_DIV) @(posedge clk);
        #1;
        wrap_cnt++;
        if (wrap_cnt % 8 == 0) model_boundary();
    endtask

    task automatic to_boundary();
        do wait_wrap(); while (wrap_cnt % 8 != 0);
    endtask

    task automatic push_frame();
        for (int d = 0; d < 8; d++) sb.push_back(expect_digit(d));
    endtask

    task automatic set_field(input int s, input int v);
        bus.state = 3'(s);
        case (s)
            1:       bus.player_count   = 3'(v);
            2:       bus.question_count = 4'(v);
            3:       bus.answer_time    = 7'(v);
            4:       bus.win_score      = 7'(v);
            5:       bus.success_score  = 4'(v);
            6:       bus.fail_score     = 4'(v);
            default: ;
        endcase
    endtask

    task automatic test_reset();
        exp_t e;
        bus.view = 3'd0;
        bus.state = 3'd0;
        bus.player_count = 3'd0; bus.question_count = 4'd0;
        bus.answer_time = 7'd0;  bus.win_score = 7'd0;
        bus.success_score = 4'd0; bus.fail_score = 4'd0;
        set_field(1, 3);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.seg_en !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL reset_async_en: got %h, wanted ff", bus.seg_en);
        end
        checks++;
        if (bus.seg_out !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL reset_async_out: got %h, wanted ff", bus.seg_out);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int w = 1; w < 8; w++) begin
            wait_wrap();
            checks++;
            if (bus.seg_en !== 8'hFF) begin
                failures++;
                $display("[TB] FAIL reset_dark wrap%0d: got seg_en=%h, wanted ff", w, bus.seg_en);
            end
        end
        to_boundary();
        push_frame();
        for (int d = 0; d < 8; d++) begin
            if (d > 0) wait_wrap();
            e = sb.pop_front();
            checks++;
            if (bus.seg_en !== e.en || (e.en != 8'hFF && bus.seg_out !== e.out)) begin
                failures++;
                $display("[TB] FAIL first_frame digit%0d: got en=%h seg=%h, wanted en=%h seg=%h",
                         e.digit, bus.seg_en, bus.seg_out, e.en, e.out);
            end
        end
    endtask

    task automatic test_answer_time_blink();
        exp_t e;
        set_field(3, 57);
        for (int f = 0; f < 5; f++) begin
            to_boundary();
            push_frame();
            for (int d = 0; d < 8; d++) begin
                if (d > 0) wait_wrap();
                e = sb.pop_front();
                checks++;
                if (bus.seg_en !== e.en || (e.en != 8'hFF && bus.seg_out !== e.out)) begin
                    failures++;
                    $display("[TB] FAIL answer_time frame%0d digit%0d: got en=%h seg=%h, wanted en=%h seg=%h",
                             f, e.digit, bus.seg_en, bus.seg_out, e.en, e.out);
                end
            end
        end
    endtask

    task automatic test_value_range();
        exp_t e;
        int   vals[7] = '{100, 7, 55, 10, 99, 127, 0};
        for (int f = 0; f < 7; f++) begin
            set_field(4, vals[f]);
            to_boundary();
            push_frame();
            for (int d = 0; d < 8; d++) begin
                if (d > 0) wait_wrap();
                e = sb.pop_front();
                checks++;
                if (bus.seg_en !== e.en || (e.en != 8'hFF && bus.seg_out !== e.out)) begin
                    failures++;
                    $display("[TB] FAIL win_score=%0d digit%0d: got en=%h seg=%h, wanted en=%h seg=%h",
                             vals[f], e.digit, bus.seg_en, bus.seg_out, e.en, e.out);
                end
            end
        end
    endtask

    task automatic test_fields();
        exp_t e;
        int   f_state[7] = '{1, 2, 5, 6, 0, 7, 3};
        int   f_val[7]   = '{7, 10, 0, 15, 0, 0, 99};
        for (int f = 0; f < 7; f++) begin
            set_field(f_state[f], f_val[f]);
            to_boundary();
            push_frame();
            for (int d = 0; d < 8; d++) begin
                if (d > 0) wait_wrap();
                e = sb.pop_front();
                checks++;
                if (bus.seg_en !== e.en || (e.en != 8'hFF && bus.seg_out !== e.out)) begin
                    failures++;
                    $display("[TB] FAIL field state%0d digit%0d: got en=%h seg=%h, wanted en=%h seg=%h",
                             f_state[f], e.digit, bus.seg_en, bus.seg_out, e.en, e.out);
                end
            end
        end
    endtask

    task automatic test_blink_restart();
        exp_t e;
        set_field(2, 9);
        for (int f = 0; f < 6; f++) begin
            if (f == 3) set_field(5, 12);
            to_boundary();
            push_frame();
            for (int d = 0; d < 8; d++) begin
                if (d > 0) wait_wrap();
                e = sb.pop_front();
                checks++;
                if (bus.seg_en !== e.en || (e.en != 8'hFF && bus.seg_out !== e.out)) begin
                    failures++;
                    $display("[TB] FAIL blink_restart frame%0d digit%0d: got en=%h seg=%h, wanted en=%h seg=%h",
                             f, e.digit, bus.seg_en, bus.seg_out, e.en, e.out);
                end
            end
        end
    endtask

    task automatic test_view_mid_frame();
        exp_t e;
        set_field(6, 3);
        for (int f = 0; f < 3; f++) begin
            if (f == 2) bus.view = 3'd0;
            to_boundary();
            push_frame();
            for (int d = 0; d < 8; d++) begin
                if (f == 0 && d == 4) bus.view = 3'd2;
                if (d > 0) wait_wrap();
                e = sb.pop_front();
                checks++;
                if (bus.seg_en !== e.en || (e.en != 8'hFF && bus.seg_out !== e.out)) begin
                    failures++;
                    $display("[TB] FAIL view_change frame%0d digit%0d: got en=%h seg=%h, wanted en=%h seg=%h",
                             f, e.digit, bus.seg_en, bus.seg_out, e.en, e.out);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        set_field(1, 5);
        repeat (3) wait_wrap();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.seg_en !== 8'hFF || bus.seg_out !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL mid_reset_async: got en=%h seg=%h, wanted en=ff seg=ff", bus.seg_en, bus.seg_out);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        wait_wrap();
        checks++;
        if (bus.seg_en !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL mid_reset_dark: got seg_en=%h, wanted ff", bus.seg_en);
        end
        to_boundary();
        push_frame();
        for (int d = 0; d < 8; d++) begin
            if (d > 0) wait_wrap();
            e = sb.pop_front();
            checks++;
            if (bus.seg_en !== e.en || (e.en != 8'hFF && bus.seg_out !== e.out)) begin
                failures++;
                $display("[TB] FAIL after_mid_reset digit%0d: got en=%h seg=%h, wanted en=%h seg=%h",
                         e.digit, bus.seg_en, bus.seg_out, e.en, e.out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_answer_time_blink();
        test_value_range();
        test_fields();
        test_blink_restart();
        test_view_mid_frame();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/setting_display.md
SETTING_DISPLAY -- requirements
Module: setting_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each digit is driven (>=2).
REQ-002 Parameter BLINK_FRAMES, default 25: full 8-digit frames per blink half-period (>=1).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 view  input  3  current screen; the settings page is view==0.
REQ-006 state  input  3  selected settings field, 0..6 (0 = idle, 1 player_count, 2 question_count, 3 answer_time, 4 win_score, 5 success_score, 6 fail_score).
REQ-007 player_count 3, question_count 4, answer_time 7, win_score 7, success_score 4, fail_score 4  inputs  binary setting values.
REQ-008 seg_en  output  8  digit enables, active-low, bit i = digit i (digit 7 leftmost).
REQ-009 seg_out  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.

Function
REQ-010 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on each wrap, digit index idx SHALL advance 0->1->...->7->0.
REQ-011 seg_en and seg_out SHALL be registered and SHALL change only on the edge where the scan counter wraps; seg_en SHALL equal ~(1<<idx) for the new idx.
REQ-012 On the wrap taking idx 7->0 (frame boundary), view, state and all six values SHALL be latched into a snapshot; all digit content SHALL come from the snapshot only.
REQ-013 Snapshot view!=0: seg_en SHALL be 8'hFF (all digits off); scanning continues.
REQ-014 Snapshot view==0: digit 7 = decimal state (0..6), digit 6 = '-', digits 5..2 blank, digits 1..0 = value field.
REQ-015 Value field: state 0 or state 7 -> both blank; value 0..9 -> tens blank, units digit; 10..99 -> two decimal digits; >99 -> "--".
REQ-016 Binary-to-decimal split SHALL be exact for 0..127 (tens = v/10, units = v%10).
REQ-017 Patterns: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90, '-'=BF, blank=FF; dp always off.
REQ-018 Frame counter SHALL count frame boundaries; after BLINK_FRAMES frames the blink phase SHALL toggle and the counter clear.
REQ-019 Blink phase off: digits 1..0 SHALL be blank; digits 7..2 unaffected.
REQ-020 When the latched state differs from the previous latched state, blink phase SHALL be forced on and frame counter cleared at that frame boundary (immediate feedback on field change).
REQ-021 Value change within the same field SHALL NOT restart blink.
REQ-022 Input changes mid-frame SHALL have no visible effect until the next frame boundary.

Reset
REQ-023 rst low SHALL immediately force seg_en=8'hFF, seg_out=8'hFF, scan counter 0, idx 0, frame counter 0, blink phase on, snapshot view=1 (display dark), snapshot state 0, values 0.
REQ-024 After rst rises, first digit output SHALL appear at the first scan wrap (SCAN_DIV cycles), showing digit 1 of the reset snapshot (dark); live inputs become visible after the first frame boundary.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no partial-state carryover.

Structure
REQ-026 Shared package SHALL hold segment pattern constants (digits, '-', blank) and field index constants for states 0..6.
REQ-027 One combinational sub-module seg7_decode (4-bit code in, 8-bit active-low pattern out, codes 10='-', 11..15=blank) SHALL be instantiated once on the selected digit.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 Reset release, view=0, state=1, player_count=3 -> after first frame, digit7=F9, digit6=BF, digit1=FF, digit0=B0; seg_en cycles FE,FD,...,7F every 4 clocks.
REQ-029 state=3, answer_time=57 -> digit1=92, digit0=F8; after 2 frames digits1..0=FF, after 2 more restored.
REQ-030 win_score=100 (state 4) -> digits1..0=BF,BF; win_score=7 -> digit1=FF, digit0=F8.
REQ-031 Change state 2->5 during blink-off -> at the next frame boundary digits1..0 visible, blink timer restarted.
REQ-032 view=2 mid-frame -> current frame unchanged; from next frame seg_en=FF throughout.
REQ-033 rst pulsed low for 1 cycle mid-frame -> seg_en/seg_out=FF within that cycle (asynchronous), idx restarts at 0.
